loba_div: RTL and testbench



---
 rtl/loba_div.sv | 169 ++++++++++++++++
 tb/tb_loba_div.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loba_div.sv
// Leading-one-based approximate divider: K-bit segments of A and B are divided
// bit-serially, then the quotient is rescaled by the difference of the segment shifts.
module loba_div #(
    parameter int unsigned N = 16,
    parameter int unsigned K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Q,
    output logic         dz
);

    localparam int unsigned KW = $clog2(N);
    localparam int unsigned EW = KW + 2;
    localparam int unsigned QW = 2 * K;
    localparam int unsigned CW = $clog2(QW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_DIV,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [N-1:0]  a_q, a_d, b_q, b_d;
    logic [QW-1:0] num_q, num_d;
    logic [K-1:0]  bh_q, bh_d, rem_q, rem_d;
    logic [KW-1:0] ka_q, ka_d, kb_q, kb_d;
    logic          bz_q, bz_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  res_q, res_d;
    logic          dz_q, dz_d;

    logic [K:0]    rem_sh;
    logic          div_ge;
    logic [K-1:0]  div_rem;
    logic [EW-1:0] e, e_mag;
    logic [N-1:0]  q_ext, shifted;

    // Truncation shift of x: leading-one index minus (K-1), floored at zero.
    function automatic logic [KW-1:0] seg_shift(input logic [N-1:0] x);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i]) k = KW'(i);
        end
        seg_shift = (k >= KW'(K - 1)) ? k - KW'(K - 1) : '0;
    endfunction

    function automatic logic [K-1:0] seg_val(input logic [N-1:0] x);
        seg_val = K'(x >> seg_shift(x));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_NORM;
            // A zero divisor bypasses DIV; SHIFT loads the all-ones result
            S_NORM:  state_d = (b_q == '0) ? S_SHIFT : S_DIV;
            S_DIV:   if (cnt_q == CW'(QW - 1)) state_d = S_SHIFT;
            S_SHIFT: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !rst;
        out_valid = (state_q == S_DONE);
    end

    // One restoring-division step and the signed rescale of the quotient.
    always_comb begin
        rem_sh  = {rem_q, num_q[QW-1]};
        div_ge  = (rem_sh >= {1'b0, bh_q});
        div_rem = div_ge ? K'(rem_sh - {1'b0, bh_q}) : K'(rem_sh);
        e       = EW'(ka_q) - EW'(kb_q) - EW'(K);
        e_mag   = EW'(0) - e;
        q_ext   = N'(num_q);
        shifted = e[EW-1] ? (q_ext >> e_mag) : (q_ext << e);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        num_d = num_q;
        bh_d  = bh_q;
        rem_d = rem_q;
        ka_d  = ka_q;
        kb_d  = kb_q;
        bz_d  = bz_q;
        cnt_d = cnt_q;
        res_d = res_q;
        dz_d  = dz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = A;
                    b_d = B;
                end
            end
            S_NORM: begin
                num_d = {seg_val(a_q), {K{1'b0}}};
                bh_d  = seg_val(b_q);
                ka_d  = seg_shift(a_q);
                kb_d  = seg_shift(b_q);
                bz_d  = (b_q == '0);
                rem_d = '0;
                cnt_d = '0;
            end
            S_DIV: begin
                num_d = {num_q[QW-2:0], div_ge};
                rem_d = div_rem;
                cnt_d = cnt_q + CW'(1);
            end
            S_SHIFT: begin
                res_d = bz_q ? '1 : shifted;
                dz_d  = bz_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            num_q <= '0;
            bh_q  <= '0;
            rem_q <= '0;
            ka_q  <= '0;
            kb_q  <= '0;
            bz_q  <= 1'b0;
            cnt_q <= '0;
            res_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            num_q <= num_d;
            bh_q  <= bh_d;
            rem_q <= rem_d;
            ka_q  <= ka_d;
            kb_q  <= kb_d;
            bz_q  <= bz_d;
            cnt_q <= cnt_d;
            res_q <= res_d;
            dz_q  <= dz_d;
        end
    end

    assign Q  = res_q;
    assign dz = dz_q;

endmodule

// File: tb/tb_loba_div.sv
// Self-checking bench for loba_div: directed cases, backpressure, back-to-back
// throughput and randomized jobs against an arithmetic reference model.
module tb_loba_div;

    localparam int N = 16;
    localparam int K = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Q;
    logic         dz;

    int checks = 0;
    int errors = 0;

    loba_div #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q         (Q),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    // Reference: segment = top K bits from the leading one, shift = bits dropped below it.
    function automatic void split(input int unsigned x, output int unsigned h, output int unsigned s);
        int unsigned k;
        k = 0;
        while ((x >> (k + 1)) != 0) k++;
        if (x == 0)          begin h = 0; s = 0; end
        else if (k >= K - 1) begin s = k - (K - 1); h = x >> s; end
        else                 begin s = 0; h = x; end
    endfunction

    function automatic int unsigned model_q(input int unsigned a, input int unsigned b);
        int unsigned ah, ka, bh, kb, q;
        int e;
        if (b == 0) return 32'h0000_FFFF;
        split(a, ah, ka);
        split(b, bh, kb);
        q = (ah * (1 << K)) / bh;
        e = int'(ka) - int'(kb) - K;
        if (e >= 0) return (q << e) & 32'h0000_FFFF;
        return q >> (-e);
    endfunction

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, output bit acc);
        for (int n = 0; n < 64 && !in_ready; n++) begin
            @(posedge clk); #1;
        end
        acc = in_ready;
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = N'($urandom); B = N'($urandom);
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        ok = 1'b0; lat = 0;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = n; ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; A = 16'd1000; B = 16'd10;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({in_ready, out_valid, Q, dz} !== {1'b0, 1'b0, 16'h0000, 1'b0}) begin
                errors++;
                $display("FAIL reset_state: in_ready=%0b out_valid=%0b Q=%h dz=%0b, required 0 0 0000 0",
                         in_ready, out_valid, Q, dz);
            end
        end
        in_valid = 1'b0; rst = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [5] = '{16'd1000, 16'd7, 16'd65535, 16'd123, 16'd0};
        logic [N-1:0] tb [5] = '{16'd10,   16'd2, 16'd1,     16'd0,   16'd5};
        logic [N-1:0] tq [5] = '{16'd96,   16'd3, 16'd61440, 16'hFFFF, 16'd0};
        logic         td [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int           tl [5] = '{10, 10, 10, 2, 10};
        bit acc, ok;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(ta[i], tb[i], acc);
            wait_valid(lat, ok);
            checks++;
            if (!acc || !ok || lat != tl[i] || Q !== tq[i] || dz !== td[i]) begin
                errors++;
                $display("FAIL directed_%0d: acc=%0b ok=%0b lat=%0d Q=%h dz=%0b, required lat=%0d Q=%h dz=%0b",
                         i, acc, ok, lat, Q, dz, tl[i], tq[i], td[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_handshake_%0d: out_valid=%0b in_ready=%0b, required 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        bit acc, ok;
        int lat, bad;
        out_ready = 1'b0;
        send(16'd1000, 16'd10, acc);
        wait_valid(lat, ok);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0]; A = N'($urandom); B = N'($urandom);
            @(posedge clk); #1;
            if (Q !== 16'd96 || dz !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok || lat != 10 || bad != 0) begin
            errors++;
            $display("FAIL backpressure_hold: ok=%0b lat=%0d bad_cycles=%0d Q=%h, required lat=10 bad_cycles=0 Q=0060",
                     ok, lat, bad, Q);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
        A = 16'd7; B = 16'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_next_accept: in_ready=%0b, required 0", in_ready);
        end
        wait_valid(lat, ok);
        checks++;
        if (!ok || lat != 10 || Q !== 16'd3) begin
            errors++;
            $display("FAIL backpressure_next_result: lat=%0d Q=%h, required lat=10 Q=0003", lat, Q);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit acc, ok;
        int lat;
        logic [N-1:0] a, b;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = N'($urandom); b = N'($urandom_range(1, 65535));
            A = a; B = b; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            acc = (in_ready === 1'b0);
            wait_valid(lat, ok);
            checks++;
            if (!acc || !ok || lat != 10 || Q !== 16'(model_q(a, b)) || dz !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back_%0d: acc=%0b lat=%0d Q=%h, required lat=10 Q=%h",
                         i, acc, lat, Q, 16'(model_q(a, b)));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        bit acc, ok, seen;
        int lat;
        logic [N-1:0] a, b, eq;
        logic ed;
        for (int i = 0; i < 2500; i++) begin
            a = N'($urandom) & (16'hFFFF >> $urandom_range(0, 15));
            b = ($urandom_range(0, 15) == 0) ? 16'd0 : N'($urandom) & (16'hFFFF >> $urandom_range(0, 15));
            eq = 16'(model_q(a, b));
            ed = (b == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            send(a, b, acc);
            if (i % 500 == 250) begin
                repeat (4) @(posedge clk);
                #1; rst = 1'b1;
                @(posedge clk); #1; rst = 1'b0;
                seen = 1'b0;
                for (int n = 0; n < 20; n++) begin
                    @(posedge clk); #1;
                    if (out_valid) seen = 1'b1;
                end
                checks++;
                if (seen || in_ready !== 1'b1 || Q !== 16'h0000) begin
                    errors++;
                    $display("FAIL abort_%0d: out_valid_seen=%0b in_ready=%0b Q=%h, required 0 1 0000",
                             i, seen, in_ready, Q);
                end
                continue;
            end
            wait_valid(lat, ok);
            if (!out_ready) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1;
            end
            checks++;
            if (!acc || !ok || lat != (ed ? 2 : 10) || Q !== eq || dz !== ed) begin
                errors++;
                $display("FAIL random_%0d: A=%h B=%h lat=%0d Q=%h dz=%0b, required lat=%0d Q=%h dz=%0b",
                         i, a, b, lat, Q, dz, ed ? 2 : 10, eq, ed);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
